// File: rtl/scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_t;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable 8-bit dwell down-counter with synchronous clear and a zero flag.
module scan_dwell_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Clear wins over load, load wins over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through all channels, dwelling DWELL cycles each, and
// presents the sampled bits as a frame. Define SCAN_CONT_EN for continuous scanning.
module mux_scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned DWELL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [CH_W-1:0]   sel,
    input  logic              y_in,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy
);

    localparam logic [7:0]      RELOAD  = 8'(DWELL - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    scan_state_t       r_state, w_next_state;
    logic [CH_W-1:0]   r_ch, w_ch_next;
    logic [NUM_CH-1:0] r_shadow, w_shadow_cap;
    logic              w_cnt_clr, w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic              w_capture, w_frame_load;

    scan_dwell_cnt #(.W(8)) u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (RELOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_next_state = r_state;
        w_ch_next    = r_ch;
        w_cnt_clr    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_capture    = 1'b0;
        w_frame_load = 1'b0;
        if (abort) begin
            w_next_state = IDLE;
            w_ch_next    = '0;
            w_cnt_clr    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next_state = SETTLE;
                        w_ch_next    = '0;
                        w_cnt_load   = 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_cnt_zero) begin
                        w_capture = 1'b1;
                        if (r_ch == LAST_CH) begin
                            w_next_state = HOLD;
                            w_frame_load = 1'b1;
                        end else begin
                            w_ch_next  = r_ch + 1'b1;
                            w_cnt_load = 1'b1;
                        end
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
`ifdef SCAN_CONT_EN
                        w_next_state = SETTLE;
                        w_cnt_load   = 1'b1;
`else
                        w_next_state = IDLE;
`endif
                        w_ch_next = '0;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_ch_next    = '0;
                end
            endcase
        end
    end

    // The last channel's bit goes to frame on the same edge it is sampled.
    always_comb begin
        w_shadow_cap       = r_shadow;
        w_shadow_cap[r_ch] = y_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ch     <= '0;
            r_shadow <= '0;
            frame    <= '0;
        end else begin
            r_state <= w_next_state;
            r_ch    <= w_ch_next;
            if (w_capture) begin
                r_shadow <= w_shadow_cap;
            end
            if (w_frame_load) begin
                frame <= w_shadow_cap;
            end
        end
    end

    always_comb begin
        sel = '0;
        case (r_state)
            SETTLE:  sel = r_ch;
            HOLD:    sel = LAST_CH;
            default: sel = '0;
        endcase
    end

    assign frame_valid = (r_state == HOLD);
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: two sequencers (DWELL=2 and DWELL=1), each closing the loop
// through a 4:1 mux of a pattern register. Honours SCAN_CONT_EN.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       startA = 1'b0, abortA = 1'b0, readyA = 1'b0;
    logic [3:0] iA = 4'b0000;
    logic [1:0] selA;
    logic       yA, validA, busyA;
    logic [3:0] frameA;

    logic       startB = 1'b0, abortB = 1'b0, readyB = 1'b0;
    logic [3:0] iB = 4'b0000;
    logic [1:0] selB;
    logic       yB, validB, busyB;
    logic [3:0] frameB;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign yA = iA[selA];
    assign yB = iB[selB];

    mux_scan_sequencer #(.DWELL(2)) u_dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .abort(abortA), .sel(selA),
        .y_in(yA), .frame(frameA), .frame_valid(validA), .frame_ready(readyA),
        .busy(busyA)
    );

    mux_scan_sequencer #(.DWELL(1)) u_dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .abort(abortB), .sel(selB),
        .y_in(yB), .frame(frameB), .frame_valid(validB), .frame_ready(readyB),
        .busy(busyB)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-shot scan on DUT A with handshake; leaves DUT A in IDLE.
    task automatic scanA(input logic [3:0] pat, input string tag);
        iA = pat;
        startA = 1'b1;
        step();
        startA = 1'b0;
        repeat (7) step();
        chk({tag, "_pre_valid"}, 32'(validA), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(validA), 32'd1);
        chk({tag, "_frame"}, 32'(frameA), 32'(pat));
        readyA = 1'b1;
        step();
        readyA = 1'b0;
        abortA = 1'b1;
        step();
        abortA = 1'b0;
        chk({tag, "_idle"}, 32'(busyA), 32'd0);
    endtask

    initial begin
        logic [3:0] pats [4];
        pats[0] = 4'b0011; pats[1] = 4'b1100; pats[2] = 4'b0110; pats[3] = 4'b1001;

        // Reset state
        #12;
        chk("rst_sel", 32'(selA), 32'd0);
        chk("rst_frame", 32'(frameA), 32'd0);
        chk("rst_valid", 32'(validA), 32'd0);
        chk("rst_busy", 32'(busyA), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic scan, I=1010, sel walks 0,0,1,1,2,2,3,3
        iA = 4'b1010;
        startA = 1'b1;
        step();
        startA = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("seq_sel%0d", i), 32'(selA), 32'(i / 2));
            chk($sformatf("seq_busy%0d", i), 32'(busyA), 32'd1);
            chk($sformatf("seq_valid%0d", i), 32'(validA), 32'd0);
            step();
        end
        chk("hold_valid", 32'(validA), 32'd1);
        chk("hold_frame", 32'(frameA), 32'hA);
        chk("hold_sel", 32'(selA), 32'd3);

        // Back-pressure: frame must not follow a changed input
        iA = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_valid%0d", i), 32'(validA), 32'd1);
            chk($sformatf("bp_frame%0d", i), 32'(frameA), 32'hA);
        end
        readyA = 1'b1;
        step();
        readyA = 1'b0;
        chk("hs_valid", 32'(validA), 32'd0);
        chk("hs_frame", 32'(frameA), 32'hA);
`ifdef SCAN_CONT_EN
        chk("hs_busy_cont", 32'(busyA), 32'd1);
        chk("hs_sel_cont", 32'(selA), 32'd0);
        abortA = 1'b1;
        step();
        abortA = 1'b0;
`else
        chk("hs_busy", 32'(busyA), 32'd0);
        chk("hs_sel", 32'(selA), 32'd0);
`endif
        chk("post_abort_frame", 32'(frameA), 32'hA);

        // Abort during channel 2 of I=1111 with previous frame 0000
        scanA(4'b0000, "zero");
        iA = 4'b1111;
        startA = 1'b1;
        step();
        startA = 1'b0;
        repeat (4) step();
        chk("ab_sel_pre", 32'(selA), 32'd2);
        abortA = 1'b1;
        step();
        abortA = 1'b0;
        chk("ab_busy", 32'(busyA), 32'd0);
        chk("ab_valid", 32'(validA), 32'd0);
        chk("ab_frame", 32'(frameA), 32'h0);
        repeat (6) step();
        chk("ab_busy_late", 32'(busyA), 32'd0);
        chk("ab_frame_late", 32'(frameA), 32'h0);

        // start while busy is ignored
        iA = 4'b0110;
        startA = 1'b1;
        step();
        startA = 1'b0;
        repeat (3) step();
        startA = 1'b1;
        step();
        startA = 1'b0;
        repeat (3) step();
        chk("mid_pre_valid", 32'(validA), 32'd0);
        step();
        chk("mid_valid", 32'(validA), 32'd1);
        chk("mid_frame", 32'(frameA), 32'h6);
        readyA = 1'b1;
        step();
        readyA = 1'b0;
`ifdef SCAN_CONT_EN
        abortA = 1'b1;
        step();
        abortA = 1'b0;
`endif
        repeat (10) step();
        chk("mid_no_queue", 32'(busyA), 32'd0);

        // start together with abort from IDLE
        startA = 1'b1;
        abortA = 1'b1;
        step();
        startA = 1'b0;
        abortA = 1'b0;
        chk("sa_busy", 32'(busyA), 32'd0);
        repeat (3) step();
        chk("sa_busy_late", 32'(busyA), 32'd0);

        // Asynchronous reset mid-SETTLE, then a clean rescan
        iA = 4'b1001;
        startA = 1'b1;
        step();
        startA = 1'b0;
        repeat (3) step();
        #3 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busyA), 32'd0);
        chk("ar_sel", 32'(selA), 32'd0);
        chk("ar_valid", 32'(validA), 32'd0);
        chk("ar_frame", 32'(frameA), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        scanA(4'b1001, "rescan");

        // DUT B, DWELL=1
        iB = 4'b1100;
`ifdef SCAN_CONT_EN
        readyB = 1'b1;
        startB = 1'b1;
        step();
        startB = 1'b0;
        for (int f = 0; f < 4; f++) begin
            iB = pats[f];
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("c_sel_f%0d_%0d", f, c), 32'(selB), 32'(c));
                step();
            end
            chk($sformatf("c_valid_f%0d", f), 32'(validB), 32'd1);
            chk($sformatf("c_frame_f%0d", f), 32'(frameB), 32'(pats[f]));
            step();
        end
        readyB = 1'b0;
        abortB = 1'b1;
        step();
        abortB = 1'b0;
        chk("c_abort_busy", 32'(busyB), 32'd0);
        chk("c_abort_frame", 32'(frameB), 32'(pats[3]));
`else
        startB = 1'b1;
        step();
        startB = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("d1_sel%0d", c), 32'(selB), 32'(c));
            chk($sformatf("d1_valid%0d", c), 32'(validB), 32'd0);
            step();
        end
        chk("d1_valid", 32'(validB), 32'd1);
        chk("d1_frame", 32'(frameB), 32'hC);
        readyB = 1'b1;
        step();
        readyB = 1'b0;
        chk("d1_hs_busy", 32'(busyB), 32'd0);
        chk("d1_hs_frame", 32'(frameB), 32'hC);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
